// File: rtl/core_pkg.sv
// core_pkg: shared core widths, reset/bubble constants and the fetch FSM state type
package core_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  typedef enum logic {FETCH, HOLD} fetch_state_e;
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: pipeline register with flush-over-stall priority that loads a bubble when nothing valid arrives
// ports: clk, reset (async active-low), flush, stall, load (incoming word is real),
//        instr/pc in, instr_r/pc_r/pc_plus4_r/valid_r registered out
module if_id_reg import core_pkg::*; #(
  parameter int W = XLEN,
  parameter logic [31:0] BUBBLE = NOP_INSTR
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         stall,
  input  logic         load,
  input  logic [31:0]  instr,
  input  logic [W-1:0] pc,
  output logic [31:0]  instr_r,
  output logic [W-1:0] pc_r,
  output logic [W-1:0] pc_plus4_r,
  output logic         valid_r
);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      instr_r <= BUBBLE;
      pc_r <= '0;
      pc_plus4_r <= W'(4);
      valid_r <= 1'b0;
    end else if (flush) begin
      instr_r <= BUBBLE;
      valid_r <= 1'b0;
    end else if (!stall) begin
      instr_r <= load ? instr : BUBBLE;
      valid_r <= load;
      if (load) begin
        pc_r <= pc;
        pc_plus4_r <= pc + W'(4);
      end
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: RV32I IF stage (PC, imem handshake, stall buffer, redirect kill) plus IF/ID register
// ports: clk, reset (async active-low); hazard controls StallF/StallD/FlushD/PcSrcE/PCTargetE;
//        imem_req/imem_addr/imem_rdata/imem_valid; InstrD/PCD/PCPlus4D/ValidD to Decode; FetchBusy
module fetch_stage import core_pkg::*; (
  input  logic            clk,
  input  logic            reset,
  input  logic            StallF,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic            PcSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_valid,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD,
  output logic            FetchBusy
);
  fetch_state_e state, state_n;
  logic started, kill, kill_n, done, pending, if_valid, capture;
  logic [XLEN-1:0] pcf, pcf_n, redirect_pc, redirect_pc_n, buf_pc;
  logic [31:0] buf_instr;
  // started holds the first request off until the cycle after reset release
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= FETCH;
      started <= 1'b0;
      pcf <= RESET_PC;
      kill <= 1'b0;
      redirect_pc <= '0;
    end else begin
      state <= state_n;
      started <= 1'b1;
      pcf <= pcf_n;
      kill <= kill_n;
      redirect_pc <= redirect_pc_n;
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      buf_instr <= NOP_INSTR;
      buf_pc <= '0;
    end else if (capture) begin
      buf_instr <= imem_rdata;
      buf_pc <= pcf;
    end
  // a redirect during a pending beat cannot move imem_addr, so it is parked until the beat lands
  always_comb begin
    state_n = state;
    pcf_n = pcf;
    kill_n = kill;
    redirect_pc_n = redirect_pc;
    capture = 1'b0;
    if (PcSrcE) begin
      if (pending) begin
        kill_n = 1'b1;
        redirect_pc_n = PCTargetE;
      end else begin
        pcf_n = PCTargetE;
        kill_n = 1'b0;
        state_n = FETCH;
      end
    end else if (state == HOLD) begin
      if (!StallF) begin
        pcf_n = buf_pc + XLEN'(4);
        state_n = FETCH;
      end
    end else if (done) begin
      if (kill) begin
        kill_n = 1'b0;
        pcf_n = redirect_pc;
      end else if (StallF) begin
        capture = 1'b1;
        state_n = HOLD;
      end else pcf_n = pcf + XLEN'(4);
    end
  end
  always_comb begin
    imem_req = started && state == FETCH;
    done = imem_req & imem_valid;
    pending = imem_req & ~imem_valid;
    if_valid = (done & ~kill) | (state == HOLD);
  end
  assign imem_addr = pcf;
  assign FetchBusy = pending;
  if_id_reg u_if_id (
    .clk        (clk),
    .reset      (reset),
    .flush      (FlushD),
    .stall      (StallD),
    .load       (if_valid & ~PcSrcE),
    .instr      (state == HOLD ? buf_instr : imem_rdata),
    .pc         (state == HOLD ? buf_pc : pcf),
    .instr_r    (InstrD),
    .pc_r       (PCD),
    .pc_plus4_r (PCPlus4D),
    .valid_r    (ValidD)
  );
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed plus randomized checks of fetch_stage against a program-order reference model
module tb_fetch_stage;
  import core_pkg::*;
  logic clk = 1'b0, reset = 1'b0, StallF = 1'b0, StallD = 1'b0, FlushD = 1'b0, PcSrcE = 1'b0;
  logic imem_valid = 1'b0;
  logic [31:0] PCTargetE = '0, imem_rdata = '0;
  logic imem_req, FetchBusy, ValidD;
  logic [31:0] imem_addr, InstrD, PCD, PCPlus4D;
  int n_chk = 0, n_pass = 0, lat_cnt = 0, mem_lat = 0;
  bit rnd_lat = 1'b0, stray = 1'b0;
  bit m_started, m_held, m_kill, e_valid;
  logic [31:0] m_pc, m_hp, m_redir, e_instr, e_pc;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .PcSrcE(PcSrcE), .PCTargetE(PCTargetE), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid), .InstrD(InstrD), .PCD(PCD),
    .PCPlus4D(PCPlus4D), .ValidD(ValidD), .FetchBusy(FetchBusy)
  );

  // instruction memory contents: every address holds a distinct word
  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h5EED_0003;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset;
    m_started = 1'b0; m_held = 1'b0; m_kill = 1'b0;
    m_pc = RESET_PC; m_hp = '0; m_redir = '0;
    e_instr = NOP_INSTR; e_pc = '0; e_valid = 1'b0;
    lat_cnt = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_instr"}, InstrD, NOP_INSTR);
    chk({tag, "_valid"}, ValidD, 0);
    chk({tag, "_pcd"}, PCD, 0);
    chk({tag, "_pcplus4"}, PCPlus4D, 4);
    chk({tag, "_req"}, imem_req, 0);
    chk({tag, "_busy"}, FetchBusy, 0);
    chk({tag, "_addr"}, imem_addr, RESET_PC);
  endtask

  // one clock: drive memory response, check request side, advance model, check Decode side
  task automatic cycle;
    logic req, v, done, if_ok;
    logic [31:0] if_pc;
    if (rnd_lat && lat_cnt == 0) mem_lat = $urandom_range(0, 3);
    imem_valid = stray || (imem_req && lat_cnt >= mem_lat);
    imem_rdata = imem_valid ? word(imem_addr) : 32'hDEAD_BEEF;
    #1;
    req = m_started & ~m_held;
    v = imem_valid;
    done = req & v;
    chk("imem_req", imem_req, req);
    if (req) chk("imem_addr", imem_addr, m_pc);
    chk("fetch_busy", FetchBusy, req & ~v);
    if_ok = (done & ~m_kill) | m_held;
    if_pc = m_held ? m_hp : m_pc;
    if (FlushD) begin
      e_instr = NOP_INSTR; e_valid = 1'b0;
    end else if (!StallD) begin
      if (if_ok && !PcSrcE) begin
        e_instr = word(if_pc); e_pc = if_pc; e_valid = 1'b1;
      end else begin
        e_instr = NOP_INSTR; e_valid = 1'b0;
      end
    end
    if (PcSrcE) begin
      if (req && !v) begin
        m_kill = 1'b1; m_redir = PCTargetE;
      end else begin
        m_pc = PCTargetE; m_held = 1'b0; m_kill = 1'b0;
      end
    end else if (m_held) begin
      if (!StallF) begin
        m_pc = m_hp + 32'd4; m_held = 1'b0;
      end
    end else if (done) begin
      if (m_kill) begin
        m_kill = 1'b0; m_pc = m_redir;
      end else if (StallF) begin
        m_held = 1'b1; m_hp = m_pc;
      end else m_pc = m_pc + 32'd4;
    end
    m_started = 1'b1;
    if (imem_req && imem_valid) lat_cnt = 0;
    else if (imem_req) lat_cnt++;
    @(posedge clk);
    #1;
    chk("valid_d", ValidD, e_valid);
    chk("instr_d", InstrD, e_instr);
    if (e_valid) begin
      chk("pc_d", PCD, e_pc);
      chk("pcplus4_d", PCPlus4D, e_pc + 32'd4);
    end
    stray = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    model_reset;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b1;
    stray = 1'b1;
    cycle;
    cycle;
    mem_lat = 3;
    repeat (4) cycle;
    mem_lat = 0;
    StallF = 1'b1; StallD = 1'b1;
    cycle;
    cycle;
    StallF = 1'b0; StallD = 1'b0;
    cycle;
    cycle;
    mem_lat = 2;
    PcSrcE = 1'b1; PCTargetE = 32'h100;
    cycle;
    PcSrcE = 1'b0;
    cycle;
    cycle;
    mem_lat = 0;
    cycle;
    FlushD = 1'b1; StallD = 1'b1;
    cycle;
    FlushD = 1'b0; StallD = 1'b0;
    PcSrcE = 1'b1; PCTargetE = 32'h20;
    cycle;
    PcSrcE = 1'b0;
    mem_lat = 5;
    cycle;
    cycle;
    #2 reset = 1'b0;
    #1 check_reset_outputs("async_reset");
    model_reset;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    mem_lat = 0;
    stray = 1'b1;
    cycle;
    cycle;
    cycle;
    PcSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC;
    cycle;
    PcSrcE = 1'b0;
    cycle;
    cycle;
    rnd_lat = 1'b1;
    repeat (400) begin
      StallF = $urandom_range(0, 3) == 0;
      StallD = StallF ? $urandom_range(0, 1) == 1 : $urandom_range(0, 7) == 0;
      FlushD = $urandom_range(0, 9) == 0;
      PcSrcE = $urandom_range(0, 9) == 0;
      PCTargetE = 32'($urandom_range(0, 1023)) << 2;
      cycle;
    end
    StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PcSrcE = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
